// File: rtl/bypass_scoreboard.sv
// Operand-forwarding scoreboard: tracks in-flight destinations per stage/lane, forwards the
// youngest matching result to each read port, flags not-yet-ready producers and retires in order.

module bypass_entry #(
  parameter int XLEN  = 64,
  parameter int SW    = 2,
  parameter int STAGE = 0
) (
  input  logic            v,
  input  logic            wen,
  input  logic            rdy,
  input  logic            kill,
  input  logic            res_valid,
  input  logic [SW-1:0]   res_stage,
  input  logic [XLEN-1:0] data,
  input  logic [XLEN-1:0] res_data,
  output logic            live,
  output logic            prod,
  output logic            rdy_eff,
  output logic [XLEN-1:0] data_eff
);
  logic res_hit;

  // A flushed entry drops any result aimed at it in the same cycle.
  assign live     = v & ~kill;
  assign prod     = live & wen;
  assign res_hit  = res_valid & prod & (res_stage == SW'(STAGE));
  assign rdy_eff  = rdy | res_hit;
  assign data_eff = res_hit ? res_data : data;
endmodule

module bypass_port #(
  parameter int XLEN    = 64,
  parameter int RIW     = 5,
  parameter int NSTAGES = 4,
  parameter int NLANES  = 2
) (
  input  logic [RIW-1:0]                          idx,
  input  logic [XLEN-1:0]                         rf,
  input  logic [NSTAGES-1:0][NLANES-1:0]          prod,
  input  logic [NSTAGES-1:0][NLANES-1:0]          rdy,
  input  logic [NSTAGES-1:0][NLANES-1:0][RIW-1:0] rd,
  input  logic [NSTAGES-1:0][NLANES-1:0][XLEN-1:0] data,
  output logic [XLEN-1:0]                         op,
  output logic                                    hit,
  output logic                                    pend
);
  logic            found;
  logic            f_rdy;
  logic [XLEN-1:0] f_data;

  // Scan oldest to youngest so the last match written is the youngest producer.
  always_comb begin
    found  = 1'b0;
    f_rdy  = 1'b0;
    f_data = '0;
    for (int s = NSTAGES - 1; s >= 0; s--) begin
      for (int l = 0; l < NLANES; l++) begin
        if (prod[s][l] && (rd[s][l] == idx) && (idx != '0)) begin
          found  = 1'b1;
          f_rdy  = rdy[s][l];
          f_data = data[s][l];
        end
      end
    end
  end

  assign hit  = found & f_rdy;
  assign pend = found & ~f_rdy;
  assign op   = hit ? f_data : rf;
endmodule

module bypass_scoreboard #(
  parameter int XLEN    = 64,
  parameter int NLANES  = 2,
  parameter int NSTAGES = 4,
  parameter int NRD     = 4,
  parameter int RIW     = 5
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                adv,
  input  logic [NLANES-1:0]                   issue_valid,
  input  logic [NLANES-1:0]                   issue_wen,
  input  logic [NLANES*RIW-1:0]               issue_rd,
  input  logic [NLANES-1:0]                   res_valid,
  input  logic [NLANES*$clog2(NSTAGES)-1:0]   res_stage,
  input  logic [NLANES*XLEN-1:0]              res_data,
  input  logic [NSTAGES-1:0]                  flush_mask,
  input  logic [NRD*RIW-1:0]                  rd_idx,
  input  logic [NRD*XLEN-1:0]                 rf_data,
  output logic [NRD*XLEN-1:0]                 op_data,
  output logic [NRD-1:0]                      op_hit,
  output logic                                stall,
  output logic [NLANES-1:0]                   ret_valid,
  output logic [NLANES*RIW-1:0]               ret_rd,
  output logic [NLANES*XLEN-1:0]              ret_data
);
  localparam int SW = $clog2(NSTAGES);

  typedef struct packed {
    logic            v;
    logic            wen;
    logic [RIW-1:0]  rd;
    logic            rdy;
    logic [XLEN-1:0] data;
  } entry_t;

  entry_t [NSTAGES-1:0][NLANES-1:0]          ent;
  entry_t [NSTAGES-1:0][NLANES-1:0]          upd;
  logic   [NSTAGES-1:0][NLANES-1:0]          live;
  logic   [NSTAGES-1:0][NLANES-1:0]          prod;
  logic   [NSTAGES-1:0][NLANES-1:0]          rdy_eff;
  logic   [NSTAGES-1:0][NLANES-1:0][RIW-1:0] ent_rd;
  logic   [NSTAGES-1:0][NLANES-1:0][XLEN-1:0] data_eff;

  logic [NLANES-1:0][RIW-1:0]  i_rd;
  logic [NLANES-1:0][SW-1:0]   r_stage;
  logic [NLANES-1:0][XLEN-1:0] r_data;
  logic [NLANES-1:0][RIW-1:0]  t_rd;
  logic [NLANES-1:0][XLEN-1:0] t_data;
  logic [NLANES-1:0]           ret_bad;

  logic [NRD-1:0][RIW-1:0]  idx;
  logic [NRD-1:0][XLEN-1:0] rf;
  logic [NRD-1:0][XLEN-1:0] op;
  logic [NRD-1:0]           pend;

  assign i_rd    = issue_rd;
  assign r_stage = res_stage;
  assign r_data  = res_data;
  assign idx     = rd_idx;
  assign rf      = rf_data;

  for (genvar s = 0; s < NSTAGES; s++) begin : g_stage
    for (genvar l = 0; l < NLANES; l++) begin : g_lane
      bypass_entry #(.XLEN(XLEN), .SW(SW), .STAGE(s)) u_ent (
        .v        (ent[s][l].v),
        .wen      (ent[s][l].wen),
        .rdy      (ent[s][l].rdy),
        .kill     (flush_mask[s]),
        .res_valid(res_valid[l]),
        .res_stage(r_stage[l]),
        .data     (ent[s][l].data),
        .res_data (r_data[l]),
        .live     (live[s][l]),
        .prod     (prod[s][l]),
        .rdy_eff  (rdy_eff[s][l]),
        .data_eff (data_eff[s][l])
      );
    end
  end

  // Post-flush, post-result view of every entry; this is what holds or shifts.
  always_comb begin
    upd    = '0;
    ent_rd = '0;
    for (int s = 0; s < NSTAGES; s++) begin
      for (int l = 0; l < NLANES; l++) begin
        ent_rd[s][l] = ent[s][l].rd;
        upd[s][l]    = '{v: live[s][l], wen: ent[s][l].wen, rd: ent[s][l].rd,
                         rdy: rdy_eff[s][l], data: data_eff[s][l]};
      end
    end
  end

  for (genvar p = 0; p < NRD; p++) begin : g_port
    bypass_port #(.XLEN(XLEN), .RIW(RIW), .NSTAGES(NSTAGES), .NLANES(NLANES)) u_port (
      .idx (idx[p]),
      .rf  (rf[p]),
      .prod(prod),
      .rdy (rdy_eff),
      .rd  (ent_rd),
      .data(data_eff),
      .op  (op[p]),
      .hit (op_hit[p]),
      .pend(pend[p])
    );
  end

  assign op_data = op;
  assign stall   = |pend;

  always_comb begin
    ret_valid = '0;
    t_rd      = '0;
    t_data    = '0;
    ret_bad   = '0;
    for (int l = 0; l < NLANES; l++) begin
      ret_bad[l] = adv & prod[NSTAGES-1][l] & ~rdy_eff[NSTAGES-1][l];
      if (adv && prod[NSTAGES-1][l] && rdy_eff[NSTAGES-1][l]) begin
        ret_valid[l] = 1'b1;
        t_rd[l]      = ent[NSTAGES-1][l].rd;
        t_data[l]    = data_eff[NSTAGES-1][l];
      end
    end
  end

  assign ret_rd   = t_rd;
  assign ret_data = t_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ent <= '0;
    end else if (adv) begin
      for (int l = 0; l < NLANES; l++) begin
        if (issue_valid[l] && !flush_mask[0])
          ent[0][l] <= '{v: 1'b1, wen: issue_wen[l], rd: i_rd[l], rdy: 1'b0, data: '0};
        else
          ent[0][l] <= '0;
      end
      for (int s = 1; s < NSTAGES; s++) ent[s] <= upd[s-1];
    end else begin
      ent <= upd;
    end
  end

  // Upstream must never let a producer leave the last stage without its result.
  a_retire_ready: assert property (@(posedge clk) disable iff (!rst_n) ret_bad == '0);
endmodule

// File: tb/tb_bypass_scoreboard.sv
// Directed bench for bypass_scoreboard: read-port and retire expectations are queued as
// stimulus is driven and popped against the DUT before each rising edge.
module tb_bypass_scoreboard;
  localparam int XLEN = 64, NLANES = 2, NSTAGES = 4, NRD = 4, RIW = 5, SW = 2;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     adv;
  logic [NLANES-1:0]        issue_valid, issue_wen, res_valid, ret_valid;
  logic [NLANES*RIW-1:0]    issue_rd, ret_rd;
  logic [NLANES*SW-1:0]     res_stage;
  logic [NLANES*XLEN-1:0]   res_data, ret_data;
  logic [NSTAGES-1:0]       flush_mask;
  logic [NRD*RIW-1:0]       rd_idx;
  logic [NRD*XLEN-1:0]      rf_data, op_data;
  logic [NRD-1:0]           op_hit;
  logic                     stall;
  logic                     exp_noret = 1'b0;
  int                       n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  bypass_scoreboard #(.XLEN(XLEN), .NLANES(NLANES), .NSTAGES(NSTAGES), .NRD(NRD), .RIW(RIW)) dut (
    .clk(clk), .rst_n(rst_n), .adv(adv),
    .issue_valid(issue_valid), .issue_wen(issue_wen), .issue_rd(issue_rd),
    .res_valid(res_valid), .res_stage(res_stage), .res_data(res_data),
    .flush_mask(flush_mask), .rd_idx(rd_idx), .rf_data(rf_data),
    .op_data(op_data), .op_hit(op_hit), .stall(stall),
    .ret_valid(ret_valid), .ret_rd(ret_rd), .ret_data(ret_data)
  );

  typedef struct {string tag; int port; logic [XLEN-1:0] data; logic hit; logic stl;} rd_exp_t;
  typedef struct {logic [RIW-1:0] rd; logic [XLEN-1:0] data;} ret_exp_t;
  rd_exp_t  rdq[$];
  ret_exp_t retq[$];

  task automatic check(string tag, logic [XLEN-1:0] got, logic [XLEN-1:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle();
    adv = 1'b0; issue_valid = '0; issue_wen = '0; issue_rd = '0;
    res_valid = '0; res_stage = '0; res_data = '0; flush_mask = '0; rd_idx = '0;
    for (int p = 0; p < NRD; p++) rf_data[p*XLEN +: XLEN] = {$urandom, $urandom};
  endtask

  task automatic issue(int l, logic [RIW-1:0] rd);
    adv = 1'b1; issue_valid[l] = 1'b1; issue_wen[l] = 1'b1; issue_rd[l*RIW +: RIW] = rd;
  endtask

  task automatic expect_retire(logic [RIW-1:0] rd, logic [XLEN-1:0] d);
    ret_exp_t e;
    e.rd = rd; e.data = d;
    retq.push_back(e);
  endtask

  task automatic result(int l, int s, logic [XLEN-1:0] d);
    res_valid[l] = 1'b1; res_stage[l*SW +: SW] = SW'(s); res_data[l*XLEN +: XLEN] = d;
  endtask

  task automatic read(string tag, int p, logic [RIW-1:0] idx, logic [XLEN-1:0] d, logic hit, logic stl);
    rd_exp_t e;
    rd_idx[p*RIW +: RIW] = idx;
    e.tag = tag; e.port = p; e.data = d; e.hit = hit; e.stl = stl;
    rdq.push_back(e);
  endtask

  task automatic read_rf(string tag, int p, logic [RIW-1:0] idx, logic stl);
    read(tag, p, idx, rf_data[p*XLEN +: XLEN], 1'b0, stl);
  endtask

  // Settle, drain expectations, then cross one rising edge and return at the falling edge.
  task automatic tick();
    rd_exp_t  e;
    ret_exp_t r;
    #1;
    while (rdq.size() > 0) begin
      e = rdq.pop_front();
      check({e.tag, "/data"}, op_data[e.port*XLEN +: XLEN], e.data);
      check({e.tag, "/hit"}, XLEN'(op_hit[e.port]), XLEN'(e.hit));
      check({e.tag, "/stall"}, XLEN'(stall), XLEN'(e.stl));
    end
    if (exp_noret) begin
      check("noret/ret_valid", XLEN'(ret_valid), '0);
      exp_noret = 1'b0;
    end
    for (int l = 0; l < NLANES; l++) begin
      if (ret_valid[l]) begin
        r.rd = 'x; r.data = 'x;
        if (retq.size() > 0) r = retq.pop_front();
        check($sformatf("retire%0d/rd", l), XLEN'(ret_rd[l*RIW +: RIW]), XLEN'(r.rd));
        check($sformatf("retire%0d/data", l), ret_data[l*XLEN +: XLEN], r.data);
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // state straight out of reset
    idle(); read_rf("init_p0", 0, 1, 0); read_rf("init_p1", 1, 2, 0);
    read_rf("init_p2", 2, 3, 0); read_rf("init_p3", 3, 31, 0); exp_noret = 1'b1; tick();

    // reset with three unready live entries
    idle(); issue(0, 3); issue(1, 4); tick();
    idle(); issue(0, 6); tick();
    idle(); read_rf("live_x3", 0, 3, 1); read_rf("live_x6", 1, 6, 1);
    read_rf("live_x0", 2, 0, 1); read_rf("live_x1", 3, 1, 1); tick();
    idle(); rst_n = 1'b0; issue(0, 8); issue(1, 9); result(0, 1, 64'h99); tick();
    rst_n = 1'b1;
    idle(); read_rf("rst_x3", 0, 3, 0); read_rf("rst_x4", 1, 4, 0);
    read_rf("rst_x6", 2, 6, 0); read_rf("rst_x0", 3, 0, 0); exp_noret = 1'b1; tick();

    // youngest stage wins
    idle(); issue(0, 5); expect_retire(5, 64'h11); tick();
    idle(); result(0, 0, 64'h11); tick();
    idle(); adv = 1'b1; tick();
    idle(); issue(0, 5); expect_retire(5, 64'h22); tick();
    idle(); result(0, 0, 64'h22); read("same_cycle_fwd", 1, 5, 64'h22, 1, 0); tick();
    idle(); read("youngest", 0, 5, 64'h22, 1, 0); read_rf("miss_x4", 3, 4, 0);
    read_rf("x0_idle", 2, 0, 0); tick();

    // youngest lane wins within a stage
    idle(); issue(0, 7); issue(1, 7); expect_retire(7, 64'hA); expect_retire(7, 64'hB); tick();
    idle(); result(0, 0, 64'hA); result(1, 0, 64'hB); tick();
    idle(); read("lane_order", 0, 7, 64'hB, 1, 0); read("older_stage", 1, 5, 64'h22, 1, 0); tick();

    // load-use: stall, then same-cycle result, then registered result
    idle(); issue(0, 9); expect_retire(9, 64'h55); tick();
    idle(); read_rf("load_use", 0, 9, 1); read("load_use_other", 1, 7, 64'hB, 1, 1); tick();
    idle(); result(0, 0, 64'h55); read("load_use_fwd", 0, 9, 64'h55, 1, 0); tick();
    idle(); read("load_use_reg", 2, 9, 64'h55, 1, 0); tick();

    // x0 never matches
    idle(); issue(0, 0); expect_retire(0, 64'hFF); tick();
    idle(); result(0, 0, 64'hFF); read_rf("x0_fwd", 0, 0, 0); read("x9", 1, 9, 64'h55, 1, 0); tick();
    idle(); read_rf("x0_guard", 0, 0, 0); read_rf("x0_guard3", 3, 0, 0); tick();

    // drain everything through retirement
    repeat (4) begin idle(); adv = 1'b1; tick(); end

    // flush of stages 0/1 together with an issue
    idle(); issue(0, 10); issue(1, 11); expect_retire(10, 64'h77); expect_retire(11, 64'h88); tick();
    idle(); result(0, 0, 64'h77); result(1, 0, 64'h88); tick();
    idle(); issue(0, 14); tick();
    idle(); issue(0, 12); issue(1, 13); tick();
    idle(); read_rf("pre_flush", 0, 14, 1); read("pre_flush_hit", 1, 10, 64'h77, 1, 1); tick();
    idle(); flush_mask = 4'b0011; issue(0, 15); issue(1, 16);
    result(0, 1, 64'hCC); result(1, 0, 64'hDD);
    read_rf("flush_x12", 0, 12, 0); read_rf("flush_x14", 1, 14, 0);
    read("flush_old", 2, 11, 64'h88, 1, 0); read_rf("flush_x15", 3, 15, 0); tick();
    idle(); read_rf("gone_x12", 0, 12, 0); read_rf("gone_x13", 1, 13, 0);
    read_rf("gone_x15", 2, 15, 0); read_rf("gone_x16", 3, 16, 0); tick();
    idle(); adv = 1'b1; read("ret_cycle", 0, 10, 64'h77, 1, 0); tick();
    idle(); exp_noret = 1'b1; tick();

    check("retire_queue_empty", XLEN'(retq.size()), '0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
